// File: rtl/rv32i_pkg.sv
// Shared RV32I sequencer definitions: opcode values, result-mux encodings,
// sequencer states and instruction classes.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_LINK = 2'b10;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} mc_state_e;

    typedef enum logic [2:0] {LD, ST, ALU, BR, JMP, UPPER, ILL} instr_class_e;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational opcode classifier: maps a RV32I opcode to the sequencing
// class that decides which states an instruction visits.
module instr_class_dec
    import rv32i_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_e instr_class
);

    always_comb begin
        case (opcode)
            OPC_LOAD:             instr_class = LD;
            OPC_STORE:            instr_class = ST;
            OPC_OP, OPC_OP_IMM:   instr_class = ALU;
            OPC_BRANCH:           instr_class = BR;
            OPC_JAL, OPC_JALR:    instr_class = JMP;
            OPC_LUI, OPC_AUIPC:   instr_class = UPPER;
            default:              instr_class = ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to halt on unknown opcodes and expose illegal_instr_o.
module multicycle_ctrl
    import rv32i_pkg::*;
#(
    parameter int INSTRET_W   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct_3_i,
    input  logic                 branch_taken_i,
    output logic                 imem_req_o,
    input  logic                 imem_ready_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    input  logic                 dmem_ready_i,
    output logic                 ir_wr_en_o,
    output logic                 pc_wr_en_o,
    output logic                 pc_sel_o,
    output logic                 reg_wr_en_o,
    output logic [1:0]           result_src_o,
    output logic                 instr_done_o,
    output logic [INSTRET_W-1:0] instret_o,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    output logic                 illegal_instr_o,
`endif
    output logic                 bus_err_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    mc_state_e            state_reg, state_next;
    logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [INSTRET_W-1:0] instret_reg;
    logic                 bus_err_reg, bus_err_next;
    instr_class_e         instr_class;
    logic                 timeout_hit, retire;
    logic                 imem_req, dmem_req, dmem_we, ir_wr_en, pc_sel, reg_wr_en;
    logic [1:0]           result_src;
    logic                 unused_funct3;

    // Access width is consumed by the memory side, not by the sequencer.
    assign unused_funct3 = ^funct_3_i;

    instr_class_dec u_class_dec (
        .opcode      (opcode_i),
        .instr_class (instr_class)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_reg, illegal_next;
`endif

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        bus_err_next  = bus_err_reg;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_wr_en      = 1'b0;
        pc_sel        = 1'b0;
        reg_wr_en     = 1'b0;
        result_src    = RES_ALU;
        retire        = 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        illegal_next  = illegal_reg;
`endif
        case (state_reg)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready_i) begin
                    ir_wr_en   = 1'b1;
                    state_next = DECODE;
                end else if (timeout_hit) begin
                    bus_err_next = 1'b1;
                    state_next   = HALT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            DECODE: begin
                state_next = EXEC;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                if (instr_class == ILL) begin
                    illegal_next = 1'b1;
                    state_next   = HALT;
                end
`endif
            end
            EXEC: begin
                case (instr_class)
                    LD, ST:          state_next = MEM;
                    ALU, JMP, UPPER: state_next = WB;
                    BR: begin
                        pc_sel     = branch_taken_i;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    // Unknown opcodes fall through here as a NOP.
                    default: begin
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (instr_class == ST);
                if (dmem_ready_i) begin
                    retire     = (instr_class == ST);
                    state_next = (instr_class == ST) ? FETCH : WB;
                end else if (timeout_hit) begin
                    bus_err_next = 1'b1;
                    state_next   = HALT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            WB: begin
                reg_wr_en  = 1'b1;
                pc_sel     = (instr_class == JMP);
                result_src = (instr_class == LD)  ? RES_MEM  :
                             (instr_class == JMP) ? RES_LINK : RES_ALU;
                retire     = 1'b1;
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
            instret_reg  <= '0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            bus_err_reg  <= bus_err_next;
            if (retire) begin
                instret_reg <= instret_reg + INSTRET_W'(1);
            end
        end
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            illegal_reg <= 1'b0;
        end else begin
            illegal_reg <= illegal_next;
        end
    end

    assign illegal_instr_o = rst_n_i & illegal_reg;
`endif

    // Everything is forced low while reset is held, abandoning any access in flight.
    assign imem_req_o   = rst_n_i & imem_req;
    assign dmem_req_o   = rst_n_i & dmem_req;
    assign dmem_we_o    = rst_n_i & dmem_we;
    assign ir_wr_en_o   = rst_n_i & ir_wr_en;
    assign pc_wr_en_o   = rst_n_i & retire;
    assign pc_sel_o     = rst_n_i & pc_sel;
    assign reg_wr_en_o  = rst_n_i & reg_wr_en;
    assign result_src_o = rst_n_i ? result_src : 2'b00;
    assign instr_done_o = rst_n_i & retire;
    assign instret_o    = rst_n_i ? instret_reg : '0;
    assign bus_err_o    = rst_n_i & bus_err_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random instruction streams with random memory wait states, checked every
// cycle against a per-instruction cycle-sequence model; plus timeout/illegal directed runs.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic        imem_req;
        logic        dmem_req;
        logic        dmem_we;
        logic        ir_wr_en;
        logic        pc_wr_en;
        logic        pc_sel;
        logic        reg_wr_en;
        logic [1:0]  result_src;
        logic        instr_done;
        logic [31:0] instret;
        logic        bus_err;
    } outs_t;

    typedef struct packed {
        logic       rst_n;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic       taken;
        logic       imem_ready;
        logic       dmem_ready;
    } ins_t;

    localparam int C_LD = 0, C_ST = 1, C_ALU = 2, C_BR = 3, C_JMP = 4, C_UP = 5, C_ILL = 6;

    logic clk;
    logic rst_n, branch_taken, imem_ready, dmem_ready;
    logic [6:0] opcode;
    logic [2:0] funct_3;
    logic imem_req, dmem_req, dmem_we, ir_wr_en, pc_wr_en, pc_sel, reg_wr_en, instr_done, bus_err;
    logic [1:0] result_src;
    logic [31:0] instret;

    logic t_rst_n, t_taken, t_imem_ready, t_dmem_ready;
    logic [6:0] t_opcode;
    logic t_imem_req, t_dmem_req, t_dmem_we, t_ir_wr_en, t_pc_wr_en, t_pc_sel, t_reg_wr_en, t_instr_done, t_bus_err;
    logic [1:0] t_result_src;
    logic [31:0] t_instret;
    logic ill_main, t_illegal;

    int n_checks = 0;
    int n_fail = 0;
    int m_instret = 0;
    int budget = -1;
    int n_emit = 0;
    int cyc = 0;
    bit chk_en = 0;
    outs_t exp_cur;
    ins_t  in_q[$];
    outs_t exp_q[$];

    multicycle_ctrl u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .funct_3_i(funct_3),
        .branch_taken_i(branch_taken), .imem_req_o(imem_req), .imem_ready_i(imem_ready),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ready_i(dmem_ready),
        .ir_wr_en_o(ir_wr_en), .pc_wr_en_o(pc_wr_en), .pc_sel_o(pc_sel),
        .reg_wr_en_o(reg_wr_en), .result_src_o(result_src), .instr_done_o(instr_done),
        .instret_o(instret),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        .illegal_instr_o(ill_main),
`endif
        .bus_err_o(bus_err)
    );

    multicycle_ctrl #(.INSTRET_W(32), .MEM_TIMEOUT(4)) u_to (
        .clk_i(clk), .rst_n_i(t_rst_n), .opcode_i(t_opcode), .funct_3_i(3'b010),
        .branch_taken_i(t_taken), .imem_req_o(t_imem_req), .imem_ready_i(t_imem_ready),
        .dmem_req_o(t_dmem_req), .dmem_we_o(t_dmem_we), .dmem_ready_i(t_dmem_ready),
        .ir_wr_en_o(t_ir_wr_en), .pc_wr_en_o(t_pc_wr_en), .pc_sel_o(t_pc_sel),
        .reg_wr_en_o(t_reg_wr_en), .result_src_o(t_result_src), .instr_done_o(t_instr_done),
        .instret_o(t_instret),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        .illegal_instr_o(t_illegal),
`endif
        .bus_err_o(t_bus_err)
    );

`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    assign ill_main  = 1'b0;
    assign t_illegal = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // RV32I opcode map, independent of the design's own decoder.
    function automatic int cls_of(input logic [6:0] opc);
        case (opc)
            7'h03:        return C_LD;
            7'h23:        return C_ST;
            7'h33, 7'h13: return C_ALU;
            7'h63:        return C_BR;
            7'h6F, 7'h67: return C_JMP;
            7'h37, 7'h17: return C_UP;
            default:      return C_ILL;
        endcase
    endfunction

    function automatic ins_t noise(input logic [6:0] opc);
        ins_t i;
        i.rst_n      = 1'b1;
        i.opcode     = opc;
        i.f3         = 3'($urandom);
        i.taken      = 1'($urandom);
        i.imem_ready = 1'($urandom);
        i.dmem_ready = 1'($urandom);
        return i;
    endfunction

    function automatic void emit(input ins_t i, input outs_t o, input bit ret);
        if (budget == 0) return;
        if (budget > 0) budget--;
        o.instret = m_instret;
        o.bus_err = 1'b0;
        in_q.push_back(i);
        exp_q.push_back(o);
        n_emit++;
        if (ret) m_instret++;
    endfunction

    function automatic void reset_entry();
        ins_t i;
        i = noise(7'($urandom));
        i.rst_n = 1'b0;
        in_q.push_back(i);
        exp_q.push_back('0);
        m_instret = 0;
    endfunction

    // One instruction = fetch waits, ready, decode, exec, optional mem waits, optional WB.
    function automatic void gen(input logic [6:0] opc, input int wf, input int wm, input bit taken);
        int c;
        ins_t i;
        outs_t o;
        c = cls_of(opc);
        n_emit = 0;
        for (int k = 0; k <= wf; k++) begin
            i = noise(7'($urandom));
            i.imem_ready = (k == wf);
            o = '0; o.imem_req = 1'b1; o.ir_wr_en = (k == wf);
            emit(i, o, 1'b0);
        end
        i = noise(opc); o = '0;
        emit(i, o, 1'b0);
        i = noise(opc); o = '0;
        if (c == C_BR) begin
            i.taken = taken; o.pc_wr_en = 1'b1; o.instr_done = 1'b1; o.pc_sel = taken;
        end else if (c == C_ILL) begin
            o.pc_wr_en = 1'b1; o.instr_done = 1'b1;
        end
        emit(i, o, (c == C_BR) || (c == C_ILL));
        if (c == C_LD || c == C_ST) begin
            for (int k = 0; k <= wm; k++) begin
                i = noise(opc);
                i.dmem_ready = (k == wm);
                o = '0; o.dmem_req = 1'b1; o.dmem_we = (c == C_ST);
                if (k == wm && c == C_ST) begin
                    o.pc_wr_en = 1'b1; o.instr_done = 1'b1;
                end
                emit(i, o, (k == wm) && (c == C_ST));
            end
        end
        if (c == C_LD || c == C_ALU || c == C_JMP || c == C_UP) begin
            i = noise(opc); o = '0;
            o.reg_wr_en = 1'b1; o.pc_wr_en = 1'b1; o.instr_done = 1'b1;
            o.pc_sel = (c == C_JMP);
            o.result_src = (c == C_LD) ? 2'b01 : (c == C_JMP) ? 2'b10 : 2'b00;
            emit(i, o, 1'b1);
        end
    endfunction

    always @(negedge clk) begin
        outs_t act;
        if (chk_en) begin
            act.imem_req = imem_req;   act.dmem_req = dmem_req;   act.dmem_we = dmem_we;
            act.ir_wr_en = ir_wr_en;   act.pc_wr_en = pc_wr_en;   act.pc_sel = pc_sel;
            act.reg_wr_en = reg_wr_en; act.result_src = result_src;
            act.instr_done = instr_done; act.instret = instret; act.bus_err = bus_err;
            n_checks++;
            if (act !== exp_cur || ill_main !== 1'b0) begin
                n_fail++;
                $display("FAIL main cycle %0d: got %h ill=%b, expected %h ill=0", cyc, act, ill_main, exp_cur);
            end
        end
    end

    logic [6:0] opc_tab [10];
    outs_t last;

    initial begin
        ins_t ii;
        int n_opc;
        opc_tab = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h7F};
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        n_opc = 9;
`else
        n_opc = 10;
`endif
        rst_n = 1'b0; opcode = '0; funct_3 = '0; branch_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        t_rst_n = 1'b0; t_opcode = 7'h33; t_taken = 1'b0; t_imem_ready = 1'b0; t_dmem_ready = 1'b0;

        reset_entry(); reset_entry();
        gen(7'h33, 0, 0, 1'b0);
        check("model ADD latency", 64'(n_emit), 64'd4);
        last = exp_q[exp_q.size()-1];
        check("model ADD wb", {last.reg_wr_en, last.result_src}, 3'b100);
        gen(7'h03, 0, 3, 1'b0);
        check("model LW 3-wait latency", 64'(n_emit), 64'd8);
        last = exp_q[exp_q.size()-1];
        check("model LW result_src", 64'(last.result_src), 64'd1);
        gen(7'h63, 0, 0, 1'b1);
        check("model BEQ latency", 64'(n_emit), 64'd3);
        last = exp_q[exp_q.size()-1];
        check("model BEQ taken", {last.pc_sel, last.reg_wr_en}, 2'b10);
        gen(7'h63, 0, 0, 1'b0);
        gen(7'h23, 0, 0, 1'b0);
        check("model SW latency", 64'(n_emit), 64'd4);
        gen(7'h03, 0, 0, 1'b0);
        check("model LW latency", 64'(n_emit), 64'd5);
        reset_entry();
        repeat (3) gen(7'h6F, 0, 0, 1'b0);
        check("model 3 JAL instret", 64'(m_instret), 64'd3);
        gen(7'h67, 1, 0, 1'b0);
        budget = 5;
        gen(7'h23, 0, 5, 1'b0);
        budget = -1;
        reset_entry();
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
        gen(7'h7F, 0, 0, 1'b0);
        check("model NOP latency", 64'(n_emit), 64'd3);
`endif
        repeat (200) begin
            gen(opc_tab[$urandom_range(0, n_opc - 1)], $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0, 1'($urandom));
        end

        while (in_q.size() > 0) begin
            @(posedge clk); #1;
            ii = in_q.pop_front();
            rst_n = ii.rst_n; opcode = ii.opcode; funct_3 = ii.f3; branch_taken = ii.taken;
            imem_ready = ii.imem_ready; dmem_ready = ii.dmem_ready;
            exp_cur = exp_q.pop_front();
            chk_en = 1'b1;
            cyc++;
        end
        @(posedge clk); #1;
        chk_en = 1'b0;

        // Timeout instance: fetch never answered.
        @(posedge clk); #1;
        t_rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("timeout wait cycle %0d", c), {t_imem_req, t_bus_err}, 2'b10);
        end
        @(negedge clk);
        check("timeout halt", {t_imem_req, t_bus_err}, 2'b01);
        @(posedge clk); #1;
        t_imem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("halt sticky", {t_imem_req, t_ir_wr_en, t_pc_wr_en, t_bus_err}, 4'b0001);
        end
        @(posedge clk); #1;
        t_rst_n = 1'b0;
        #1;
        check("reset gating", {t_bus_err, t_imem_req}, 2'b00);
        @(posedge clk); #1;
        t_rst_n = 1'b1; t_opcode = 7'h7F;
        @(negedge clk);
        check("fetch after reset", {t_imem_req, t_ir_wr_en, t_bus_err}, 3'b110);
        @(negedge clk);
        check("illegal decode", {t_pc_wr_en, t_instr_done, t_reg_wr_en}, 3'b000);
        @(negedge clk);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        check("illegal trap", {t_illegal, t_instr_done, t_pc_wr_en}, 3'b100);
        @(negedge clk);
        check("illegal halted", {t_illegal, t_imem_req, t_instret}, {1'b1, 1'b0, 32'd0});
`else
        check("illegal nop retire", {t_pc_wr_en, t_instr_done, t_pc_sel, t_reg_wr_en, t_dmem_req}, 5'b11000);
        @(negedge clk);
        check("illegal nop next", {t_imem_req, t_instret}, {1'b1, 32'd1});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
